// File: rtl/vcve2_vec_sequencer_if.sv
// vcve2 vector sequencer: issue bundle from ID
// and operand/result bundle shared with EX.
interface vcve2_vec_sequencer_if #(
  parameter int VLEN = 128
);
  localparam int VLW = $clog2(VLEN) + 1;

  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [4:0]     vs1_i;
  logic [4:0]     vs2_i;
  logic [4:0]     vd_i;
  logic [VLW-1:0] vl_i;
  logic [2:0]     vsew_i;
  logic           scalar_sel_i;
  logic [31:0]    scalar_i;

  logic [31:0]    ex_operand_a_o;
  logic [31:0]    ex_operand_b_o;
  logic [31:0]    ex_operand_c_o;
  logic           ex_vec_instr_o;
  logic           ex_first_cycle_o;
  logic           ex_valid_i;
  logic [31:0]    ex_result_i;

  modport master (
    output issue_valid_i, vs1_i, vs2_i, vd_i,
    output vl_i, vsew_i, scalar_sel_i, scalar_i,
    output ex_valid_i, ex_result_i,
    input  issue_ready_o,
    input  ex_operand_a_o, ex_operand_b_o,
    input  ex_operand_c_o,
    input  ex_vec_instr_o, ex_first_cycle_o
  );

  modport slave (
    input  issue_valid_i, vs1_i, vs2_i, vd_i,
    input  vl_i, vsew_i, scalar_sel_i, scalar_i,
    input  ex_valid_i, ex_result_i,
    output issue_ready_o,
    output ex_operand_a_o, ex_operand_b_o,
    output ex_operand_c_o,
    output ex_vec_instr_o, ex_first_cycle_o
  );
endinterface

// File: rtl/vcve2_vec_sequencer.sv
// vcve2 vector element-loop sequencer: walks a
// register group word by word through EX into the VRF.
module vcve2_vec_sequencer #(
  parameter int VLEN = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  vcve2_vec_sequencer_if.slave    bus,
  input  logic                    kill_i,
  output logic [$clog2(VLEN)-1:0] vrf_raddr_a_o,
  output logic [$clog2(VLEN)-1:0] vrf_raddr_b_o,
  output logic [$clog2(VLEN)-1:0] vrf_raddr_c_o,
  input  logic [31:0]             vrf_rdata_a_i,
  input  logic [31:0]             vrf_rdata_b_i,
  input  logic [31:0]             vrf_rdata_c_i,
  output logic                    vrf_we_o,
  output logic [$clog2(VLEN)-1:0] vrf_waddr_o,
  output logic [31:0]             vrf_wdata_o,
  output logic [3:0]              vrf_wbe_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int AW  = $clog2(VLEN);
  localparam int WPR = VLEN / 32;
  localparam int WB  = $clog2(WPR);
  localparam int VLW = AW + 1;
  localparam int BW  = VLW + 2;
  localparam logic [BW-1:0] MAXW = BW'(8 * WPR);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  wcnt_q, wcnt_d;
  logic           first_q, first_d;
  logic [AW-1:0]  base_a_q, base_b_q, base_c_q;
  logic [BW-1:0]  words_q;
  logic [1:0]     tail_q;
  logic [1:0]     sew_q;
  logic           ssel_q;
  logic [31:0]    scalar_q;

  logic [1:0]     sew_in;
  logic [BW-1:0]  bytes_in, words_raw, words_in;
  logic           accept, last, exec;
  logic [AW-1:0]  addr_a, addr_b, addr_c;
  logic [31:0]    scal_rep;

  // Element width decode; reserved codes run as 32b
  always_comb begin
    sew_in = 2'd2;
    unique case (1'b1)
      bus.vsew_i == 3'b000: sew_in = 2'd0;
      bus.vsew_i == 3'b001: sew_in = 2'd1;
      default:              sew_in = 2'd2;
    endcase
  end

  assign bytes_in  = BW'(bus.vl_i) << sew_in;
  assign words_raw = (bytes_in + BW'(3)) >> 2;
  assign words_in  = (words_raw > MAXW) ? MAXW
                                        : words_raw;

  assign accept = (state_q == IDLE)
                & bus.issue_valid_i & ~kill_i;
  assign exec   = (state_q == EXEC);
  assign last   = BW'(wcnt_q) == (words_q - BW'(1));

  // Next state, word counter and first-cycle flag
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    first_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wcnt_d = '0;
          if (words_in != '0) begin
            state_d = EXEC;
            first_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      EXEC: begin
        if (bus.ex_valid_i) begin
          if (last) begin
            state_d = DONE;
            wcnt_d  = '0;
          end else begin
            wcnt_d  = wcnt_q + AW'(1);
            first_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) begin
      state_d = IDLE;
      wcnt_d  = '0;
      first_d = 1'b0;
    end
  end

  // State register and word counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      first_q <= first_d;
    end
  end

  // Instruction fields captured at the handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      words_q  <= '0;
      tail_q   <= '0;
      sew_q    <= '0;
      ssel_q   <= 1'b0;
      scalar_q <= '0;
    end else if (accept) begin
      base_a_q <= AW'(bus.vs1_i) << WB;
      base_b_q <= AW'(bus.vs2_i) << WB;
      base_c_q <= AW'(bus.vd_i) << WB;
      words_q  <= words_in;
      tail_q   <= bytes_in[1:0];
      sew_q    <= sew_in;
      ssel_q   <= bus.scalar_sel_i;
      scalar_q <= bus.scalar_i;
    end
  end

  // Scalar broadcast across element lanes
  always_comb begin
    scal_rep = scalar_q;
    unique case (1'b1)
      sew_q == 2'd0: scal_rep = {4{scalar_q[7:0]}};
      sew_q == 2'd1: scal_rep = {2{scalar_q[15:0]}};
      default:       scal_rep = scalar_q;
    endcase
  end

  // Group addresses wrap past v31 by AW-bit overflow
  assign addr_a = base_a_q + wcnt_q;
  assign addr_b = base_b_q + wcnt_q;
  assign addr_c = base_c_q + wcnt_q;

  // Datapath outputs are forced to zero outside EXEC
  always_comb begin
    vrf_raddr_a_o      = '0;
    vrf_raddr_b_o      = '0;
    vrf_raddr_c_o      = '0;
    vrf_waddr_o        = '0;
    vrf_wdata_o        = '0;
    vrf_wbe_o          = '0;
    bus.ex_operand_a_o = '0;
    bus.ex_operand_b_o = '0;
    bus.ex_operand_c_o = '0;
    if (exec) begin
      vrf_raddr_a_o      = addr_a;
      vrf_raddr_b_o      = addr_b;
      vrf_raddr_c_o      = addr_c;
      vrf_waddr_o        = addr_c;
      vrf_wdata_o        = bus.ex_result_i;
      vrf_wbe_o          = 4'hF;
      if (last && tail_q != 2'd0) begin
        vrf_wbe_o = (4'd1 << tail_q) - 4'd1;
      end
      bus.ex_operand_a_o = ssel_q ? scal_rep
                                  : vrf_rdata_a_i;
      bus.ex_operand_b_o = vrf_rdata_b_i;
      bus.ex_operand_c_o = vrf_rdata_c_i;
    end
  end

  assign vrf_we_o             = exec & bus.ex_valid_i
                              & ~kill_i;
  assign bus.ex_vec_instr_o   = exec;
  assign bus.ex_first_cycle_o = exec & first_q;
  assign bus.issue_ready_o    = (state_q == IDLE);
  assign busy_o               = (state_q != IDLE);
  assign done_o               = (state_q == DONE)
                              & ~kill_i;
endmodule

// File: tb/tb_vcve2_vec_sequencer.sv
// Randomized scoreboard bench for vcve2_vec_sequencer
// with a word-level reference model of the element loop.
module tb_vcve2_vec_sequencer;
  localparam int VLEN = 128;
  localparam int AW   = 7;
  localparam int NW   = 128;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          kill  = 1'b0;
  logic [AW-1:0] ra_a, ra_b, ra_c, waddr;
  logic [31:0]   rd_a, rd_b, rd_c, wdata;
  logic          we, busy, done;
  logic [3:0]    wbe;

  vcve2_vec_sequencer_if #(.VLEN(VLEN)) bus();

  vcve2_vec_sequencer #(.VLEN(VLEN)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .kill_i        (kill),
    .vrf_raddr_a_o (ra_a),
    .vrf_raddr_b_o (ra_b),
    .vrf_raddr_c_o (ra_c),
    .vrf_rdata_a_i (rd_a),
    .vrf_rdata_b_i (rd_b),
    .vrf_rdata_c_i (rd_c),
    .vrf_we_o      (we),
    .vrf_waddr_o   (waddr),
    .vrf_wdata_o   (wdata),
    .vrf_wbe_o     (wbe),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NW];
  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];
  assign rd_c = mem[ra_c];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    int          aa, ab, ac;
    logic [31:0] opa, opb, opc, wd;
    logic [3:0]  be;
  } wr_t;

  wr_t wq[$];
  int  fq[$];
  int  dq[$];
  int  lat [32];

  int          c_vs1, c_vs2, c_vd, c_vl, c_vsew;
  bit          c_ssel;
  logic [31:0] c_sc;

  function automatic logic [31:0] ex_f(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c);
    return a + (b ^ {c[15:0], c[31:16]});
  endfunction

  function automatic int sew_of(input int v);
    return (v == 0) ? 0 : (v == 1) ? 1 : 2;
  endfunction

  function automatic logic [31:0] bcast(
    input int s, input logic [31:0] sc);
    logic [31:0] r;
    int e;
    e = 1 << s;
    for (int k = 0; k < 4; k++)
      r[k*8 +: 8] = sc[(k % e)*8 +: 8];
    return r;
  endfunction

  function automatic int n_bytes();
    return c_vl * (1 << sew_of(c_vsew));
  endfunction

  function automatic int n_words();
    int w;
    w = (n_bytes() + 3) / 4;
    return (w > 32) ? 32 : w;
  endfunction

  function automatic wr_t exp_word(input int i);
    wr_t w;
    int  tail;
    tail  = n_bytes() % 4;
    w.cyc = 0;
    w.aa  = (c_vs1 * 4 + i) % NW;
    w.ab  = (c_vs2 * 4 + i) % NW;
    w.ac  = (c_vd * 4 + i) % NW;
    w.opa = c_ssel ? bcast(sew_of(c_vsew), c_sc)
                   : mem[w.aa];
    w.opb = mem[w.ab];
    w.opc = mem[w.ac];
    w.wd  = ex_f(w.opa, w.opb, w.opc);
    w.be  = (i == n_words() - 1 && tail != 0)
          ? 4'((1 << tail) - 1) : 4'hF;
    return w;
  endfunction

  task automatic predict(input int t0,
                         output int tdone);
    int  t;
    wr_t w;
    t = t0 + 1;
    for (int i = 0; i < n_words(); i++) begin
      fq.push_back(t);
      w     = exp_word(i);
      w.cyc = t + lat[i];
      wq.push_back(w);
      t = t + lat[i] + 1;
    end
    dq.push_back(t);
    tdone = t;
  endtask

  task automatic drive_issue(input int vs1,
    input int vs2, input int vd, input int vl,
    input int vsew, input bit ssel,
    input logic [31:0] sc, input int lmin,
    input int lmax);
    c_vs1 = vs1; c_vs2 = vs2; c_vd = vd;
    c_vl = vl; c_vsew = vsew;
    c_ssel = ssel; c_sc = sc;
    for (int i = 0; i < 32; i++)
      lat[i] = $urandom_range(lmax, lmin);
    bus.vs1_i        = 5'(vs1);
    bus.vs2_i        = 5'(vs2);
    bus.vd_i         = 5'(vd);
    bus.vl_i         = 8'(vl);
    bus.vsew_i       = 3'(vsew);
    bus.scalar_sel_i = ssel;
    bus.scalar_i     = sc;
    bus.issue_valid_i = 1'b1;
  endtask

  task automatic scramble();
    bus.issue_valid_i = 1'b0;
    bus.vs1_i         = 5'($urandom);
    bus.vs2_i         = 5'($urandom);
    bus.vd_i          = 5'($urandom);
    bus.vl_i          = 8'($urandom);
    bus.vsew_i        = 3'($urandom);
    bus.scalar_sel_i  = 1'($urandom);
    bus.scalar_i      = $urandom;
  endtask

  task automatic run(input int vs1, input int vs2,
    input int vd, input int vl, input int vsew,
    input bit ssel, input logic [31:0] sc,
    input int lmin, input int lmax);
    int t0, tdone;
    drive_issue(vs1, vs2, vd, vl, vsew, ssel, sc,
                lmin, lmax);
    t0 = cyc;
    predict(t0, tdone);
    @(posedge clk); #1;
    scramble();
    repeat (tdone + 1 - cyc) @(posedge clk);
    #1;
    chk("ready_after_done", 32'(bus.issue_ready_o), 1);
    chk("idle_after_done", 32'(busy), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.issue_ready_o), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_vec"}, 32'(bus.ex_vec_instr_o), 0);
    chk({tag, "_first"}, 32'(bus.ex_first_cycle_o), 0);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_raddr_a"}, 32'(ra_a), 0);
    chk({tag, "_op_a"}, bus.ex_operand_a_o, 0);
  endtask

  // EX responder: per-word latency from lat[]
  int widx = 0;
  int wcnt = 0;
  initial begin
    bus.ex_valid_i  = 1'b0;
    bus.ex_result_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !bus.ex_vec_instr_o) begin
        bus.ex_valid_i = 1'b0;
        widx = 0;
        wcnt = 0;
      end else if (wcnt >= lat[widx % 32]) begin
        bus.ex_valid_i  = 1'b1;
        bus.ex_result_i = ex_f(bus.ex_operand_a_o,
                               bus.ex_operand_b_o,
                               bus.ex_operand_c_o);
        wcnt = 0;
        widx++;
      end else begin
        bus.ex_valid_i  = 1'b0;
        bus.ex_result_i = $urandom;
        wcnt++;
      end
    end
  end

  // Monitor: compares DUT activity against queues
  initial begin
    wr_t w;
    int  f, d;
    forever begin
      @(negedge clk);
      if (bus.ex_vec_instr_o && wq.size() > 0) begin
        chk("op_a", bus.ex_operand_a_o, wq[0].opa);
        chk("op_b", bus.ex_operand_b_o, wq[0].opb);
        chk("op_c", bus.ex_operand_c_o, wq[0].opc);
        chk("raddr_a", 32'(ra_a), wq[0].aa);
        chk("raddr_b", 32'(ra_b), wq[0].ab);
        chk("raddr_c", 32'(ra_c), wq[0].ac);
      end
      if (we) begin
        vectors++;
        if (wq.size() == 0) begin
          miscompares++;
          $display("FAIL write: got addr %0d want none",
                   waddr);
        end else begin
          w = wq.pop_front();
          chk("wr_cycle", cyc, w.cyc);
          chk("waddr", 32'(waddr), w.ac);
          chk("wdata", wdata, w.wd);
          chk("wbe", 32'(wbe), 32'(w.be));
          chk("busy", 32'(busy), 1);
        end
      end
      if (bus.ex_first_cycle_o) begin
        vectors++;
        if (fq.size() == 0) begin
          miscompares++;
          $display("FAIL first: got cycle %0d want none",
                   cyc);
        end else begin
          f = fq.pop_front();
          chk("first_cycle", cyc, f);
        end
      end
      if (done) begin
        vectors++;
        if (dq.size() == 0) begin
          miscompares++;
          $display("FAIL done: got cycle %0d want none",
                   cyc);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", cyc, d);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int  t0;
    wr_t w;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    for (int i = 0; i < 32; i++) lat[i] = 0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(2, 4, 6, 4, 2, 0, 32'h0, 0, 0);
    run(1, 3, 5, 5, 0, 0, 32'h0, 0, 0);
    run(8, 9, 10, 3, 1, 0, 32'h0, 0, 0);
    run(0, 1, 31, 8, 2, 0, 32'h0, 0, 0);
    run(3, 5, 7, 8, 0, 1, 32'h0000_00AB, 0, 0);
    run(3, 5, 7, 6, 1, 1, 32'h1234_ABCD, 0, 0);
    run(12, 14, 16, 4, 2, 0, 32'h0, 3, 3);
    run(30, 29, 20, 3, 5, 1, 32'hCAFE_F00D, 0, 1);

    // kill together with the second word's ex_valid
    drive_issue(7, 9, 11, 4, 2, 0, 32'h0, 0, 0);
    t0 = cyc;
    fq.push_back(t0 + 1);
    fq.push_back(t0 + 2);
    w = exp_word(0);
    w.cyc = t0 + 1;
    wq.push_back(w);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("ready_after_kill", 32'(bus.issue_ready_o), 1);
    chk("busy_after_kill", 32'(busy), 0);
    run(4, 4, 4, 0, 2, 0, 32'h0, 0, 0);

    // kill wins over a simultaneous issue
    drive_issue(1, 2, 3, 4, 2, 0, 32'h0, 0, 0);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    chk("ready_kill_issue", 32'(bus.issue_ready_o), 1);
    chk("busy_kill_issue", 32'(busy), 0);

    // reset in the middle of an instruction
    drive_issue(5, 6, 13, 8, 2, 0, 32'h0, 0, 0);
    t0 = cyc;
    fq.push_back(t0 + 1);
    w = exp_word(0);
    w.cyc = t0 + 1;
    wq.push_back(w);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      int vl;
      vl = ($urandom_range(1, 0) == 1)
         ? $urandom_range(12, 0)
         : $urandom_range(128, 0);
      run($urandom_range(31, 0), $urandom_range(31, 0),
          $urandom_range(31, 0), vl,
          $urandom_range(7, 0), 1'($urandom),
          $urandom, 0, $urandom_range(2, 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("writes_left", wq.size(), 0);
    chk("firsts_left", fq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
